// File: rtl/inst_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package inst_mem_loader_pkg;

  localparam int unsigned ADDR_W         = 8;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned CNT_W          = 7;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  // Depth of the instruction bank in words; shared with the instruction memory.
  localparam int unsigned BANK_WORDS     = 2 ** (ADDR_W - 2);
  localparam int unsigned IDX_W          = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/inst_mem_loader_byte_to_word_packer.sv
// Collects bytes big-endian into a 32-bit word; flags the cycle the 4th byte lands.
module byte_to_word_packer
  import inst_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [DATA_W-1:0] word_c,
  output logic              word_ready_c
);

  localparam int unsigned SHIFT_W = DATA_W - BYTE_W;

  logic [IDX_W-1:0]   idx;
  logic [SHIFT_W-1:0] shift;

  // Byte index and the first three bytes of the word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      shift <= '0;
    end else if (clear) begin
      idx   <= '0;
    end else if (accept) begin
      idx   <= idx + IDX_W'(1);
      shift <= {shift[SHIFT_W-BYTE_W-1:0], byte_in};
    end
  end

  // Earlier bytes occupy the high bits; the current byte completes bits [7:0].
  always_comb begin
    word_c       = {shift, byte_in};
    word_ready_c = accept && (idx == IDX_W'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Byte-stream loader that writes big-endian words into the instruction bank.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [CNT_W-1:0]  numWords,
  input  logic              abort,
  input  logic [BYTE_W-1:0] byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              busy,
  output logic              done,
  output logic              wrapErr,
  output logic [CNT_W-1:0]  wordCount
);

  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR =
    ADDR_W'((BANK_WORDS - 1) * BYTES_PER_WORD);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES_PER_WORD - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  num_words_q, num_words_next;
  logic [ADDR_W-1:0] wr_addr_next;
  logic [DATA_W-1:0] wr_data_next;
  logic [CNT_W-1:0]  word_count_next;
  logic [CNT_W-1:0]  count_inc;
  logic              wrap_err_next;
  logic              done_next;
  logic              wr_en_next;
  logic              pack_clear;
  logic              pack_accept;
  logic [DATA_W-1:0] pack_word_c;
  logic              pack_ready_c;

  byte_to_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (pack_clear),
    .accept       (pack_accept),
    .byte_in      (byteIn),
    .word_c       (pack_word_c),
    .word_ready_c (pack_ready_c)
  );

  // Handshake and busy follow the state directly.
  always_comb begin
    byteReady = (state == RECV);
    busy      = (state != IDLE);
  end

  // Next state plus next values of the registered outputs and latched request.
  always_comb begin
    state_next      = state;
    num_words_next  = num_words_q;
    wr_addr_next    = wrAddr;
    wr_data_next    = wrData;
    word_count_next = wordCount;
    wrap_err_next   = wrapErr;
    done_next       = 1'b0;
    pack_clear      = 1'b0;
    pack_accept     = 1'b0;
    count_inc       = wordCount + CNT_W'(1);

    case (state)
      IDLE: begin
        if (abort) begin
          pack_clear = 1'b1;
        end else if (start) begin
          pack_clear    = 1'b1;
          wrap_err_next = 1'b0;
          if (numWords != '0) begin
            wr_addr_next    = startAddr & ALIGN_MASK;
            num_words_next  = numWords;
            word_count_next = '0;
            state_next      = RECV;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RECV: begin
        if (abort) begin
          pack_clear = 1'b1;
          state_next = IDLE;
        end else begin
          pack_accept = byteValid;
          if (pack_ready_c) begin
            wr_data_next = pack_word_c;
            state_next   = WRITE;
          end
        end
      end
      WRITE: begin
        if (abort) begin
          pack_clear = 1'b1;
          state_next = IDLE;
        end else begin
          word_count_next = count_inc;
          wr_addr_next    = wrAddr + ADDR_W'(BYTES_PER_WORD);
          if (count_inc == num_words_q) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RECV;
            if (wrAddr == LAST_WORD_ADDR) begin
              wrap_err_next = 1'b1;
            end
          end
        end
      end
      default: begin
        pack_clear = 1'b1;
        state_next = IDLE;
      end
    endcase

    wr_en_next = (state_next == WRITE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      num_words_q <= '0;
      wrEn        <= 1'b0;
      wrAddr      <= '0;
      wrData      <= '0;
      done        <= 1'b0;
      wrapErr     <= 1'b0;
      wordCount   <= '0;
    end else begin
      state       <= state_next;
      num_words_q <= num_words_next;
      wrEn        <= wr_en_next;
      wrAddr      <= wr_addr_next;
      wrData      <= wr_data_next;
      done        <= done_next;
      wrapErr     <= wrap_err_next;
      wordCount   <= word_count_next;
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader.
module tb_inst_mem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  startAddr;
  logic [6:0]  numWords;
  logic        abort;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        wrEn;
  logic [7:0]  wrAddr;
  logic [31:0] wrData;
  logic        busy;
  logic        done;
  logic        wrapErr;
  logic [6:0]  wordCount;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  int done_cnt;
  int ready_cnt;
  int ready_in_write;

  inst_mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .startAddr (startAddr),
    .numWords  (numWords),
    .abort     (abort),
    .byteIn    (byteIn),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .wrEn      (wrEn),
    .wrAddr    (wrAddr),
    .wrData    (wrData),
    .busy      (busy),
    .done      (done),
    .wrapErr   (wrapErr),
    .wordCount (wordCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log write strobes, done pulses and ready cycles mid-cycle.
  always @(negedge clk) begin
    if (wrEn) begin
      wq_addr.push_back(wrAddr);
      wq_data.push_back(wrData);
      if (byteReady) ready_in_write++;
    end
    if (done) done_cnt++;
    if (byteReady) ready_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    done_cnt       = 0;
    ready_cnt      = 0;
    ready_in_write = 0;
  endtask

  task automatic start_load(input logic [7:0] addr, input logic [6:0] n);
    @(posedge clk);
    #1;
    start     = 1'b1;
    startAddr = addr;
    numWords  = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic ok;
    ok        = 1'b0;
    byteIn    = b;
    byteValid = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (byteReady) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    byteValid = 1'b0;
    if (!ok) check("byte_accept", 32'd0, 32'd1);
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] tmp;
    tmp = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(tmp[31:24], gap);
      tmp = tmp << 8;
    end
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int k = 0; k < 400 && !idle; k++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input int i, input logic [7:0] a, input logic [31:0] d);
    logic [31:0] ga, gd;
    ga = 32'hDEAD_BEEF;
    gd = 32'hDEAD_BEEF;
    if (i < wq_addr.size()) begin
      ga = {24'd0, wq_addr[i]};
      gd = wq_data[i];
    end
    check({tag, "_addr"}, ga, {24'd0, a});
    check({tag, "_data"}, gd, d);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    startAddr = 8'd0;
    numWords  = 7'd0;
    abort     = 1'b0;
    byteIn    = 8'd0;
    byteValid = 1'b0;
    clear_log();

    // Reset values
    #2;
    check("rst_byteReady", {31'd0, byteReady}, 32'd0);
    check("rst_wrEn",      {31'd0, wrEn},      32'd0);
    check("rst_wrAddr",    {24'd0, wrAddr},    32'd0);
    check("rst_wrData",    wrData,             32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_wrapErr",   {31'd0, wrapErr},   32'd0);
    check("rst_wordCount", {25'd0, wordCount}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Three words at full rate
    clear_log();
    start_load(8'h00, 7'd3);
    check("t1_busy_start", {31'd0, busy}, 32'd1);
    send_word(32'h2008_0005, 0);
    send_word(32'h0000_0000, 0);
    send_word(32'hAC01_0004, 0);
    wait_idle();
    check("t1_nwrites", wq_addr.size(), 32'd3);
    check_write("t1_w0", 0, 8'h00, 32'h2008_0005);
    check_write("t1_w1", 1, 8'h04, 32'h0000_0000);
    check_write("t1_w2", 2, 8'h08, 32'hAC01_0004);
    check("t1_done_cnt",  done_cnt, 32'd1);
    check("t1_wordCount", {25'd0, wordCount}, 32'd3);
    check("t1_busy",      {31'd0, busy}, 32'd0);
    check("t1_ready_in_write", ready_in_write, 32'd0);

    // Unaligned start address is forced to a word boundary
    clear_log();
    start_load(8'h06, 7'd1);
    send_word(32'h1122_3344, 0);
    wait_idle();
    check("t2_nwrites", wq_addr.size(), 32'd1);
    check_write("t2_w0", 0, 8'h04, 32'h1122_3344);
    check("t2_wordCount", {25'd0, wordCount}, 32'd1);

    // Gapped byte stream: one byte every three cycles
    clear_log();
    start_load(8'h10, 7'd3);
    send_word(32'h2008_0005, 2);
    send_word(32'h0000_0000, 2);
    send_word(32'hAC01_0004, 2);
    wait_idle();
    check("t3_nwrites", wq_addr.size(), 32'd3);
    check_write("t3_w0", 0, 8'h10, 32'h2008_0005);
    check_write("t3_w1", 1, 8'h14, 32'h0000_0000);
    check_write("t3_w2", 2, 8'h18, 32'hAC01_0004);
    check("t3_done_cnt", done_cnt, 32'd1);
    check("t3_ready_in_write", ready_in_write, 32'd0);

    // Wrap past the top of the bank
    clear_log();
    start_load(8'hFC, 7'd2);
    check("t4_wrapErr_start", {31'd0, wrapErr}, 32'd0);
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'h0102_0304, 0);
    wait_idle();
    check("t4_nwrites", wq_addr.size(), 32'd2);
    check_write("t4_w0", 0, 8'hFC, 32'hDEAD_BEEF);
    check_write("t4_w1", 1, 8'h00, 32'h0102_0304);
    check("t4_wrapErr", {31'd0, wrapErr}, 32'd1);
    check("t4_wordCount", {25'd0, wordCount}, 32'd2);

    // Zero-length load: done next cycle, clears wrapErr, never ready
    clear_log();
    @(posedge clk);
    #1;
    start     = 1'b1;
    startAddr = 8'h40;
    numWords  = 7'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("t5_done",    {31'd0, done},    32'd1);
    check("t5_busy",    {31'd0, busy},    32'd0);
    check("t5_wrapErr", {31'd0, wrapErr}, 32'd0);
    @(negedge clk);
    check("t5_done_drop", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_nwrites",  wq_addr.size(), 32'd0);
    check("t5_ready",    ready_cnt, 32'd0);
    check("t5_done_cnt", done_cnt, 32'd1);

    // Abort after two bytes, then reload
    clear_log();
    start_load(8'h20, 7'd2);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("t6_busy",      {31'd0, busy},      32'd0);
    check("t6_byteReady", {31'd0, byteReady}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_nwrites",   wq_addr.size(),     32'd0);
    check("t6_done_cnt",  done_cnt,           32'd0);
    check("t6_wordCount", {25'd0, wordCount}, 32'd0);
    check("t6_wrAddr",    {24'd0, wrAddr},    32'h20);
    start_load(8'h30, 7'd1);
    send_word(32'h5566_7788, 0);
    wait_idle();
    check("t6_nwrites2", wq_addr.size(), 32'd1);
    check_write("t6_w0", 0, 8'h30, 32'h5566_7788);
    check("t6_done_cnt2", done_cnt, 32'd1);

    // Reset during the write cycle
    clear_log();
    start_load(8'h40, 7'd2);
    send_word(32'hCAFE_F00D, 0);
    check("t7_wrEn_pre",   {31'd0, wrEn},   32'd1);
    check("t7_wrAddr_pre", {24'd0, wrAddr}, 32'h40);
    check("t7_wrData_pre", wrData,          32'hCAFE_F00D);
    rst = 1'b1;
    #1;
    check("t7_wrEn",      {31'd0, wrEn},      32'd0);
    check("t7_wrAddr",    {24'd0, wrAddr},    32'd0);
    check("t7_wrData",    wrData,             32'd0);
    check("t7_busy",      {31'd0, busy},      32'd0);
    check("t7_byteReady", {31'd0, byteReady}, 32'd0);
    check("t7_done",      {31'd0, done},      32'd0);
    check("t7_wordCount", {25'd0, wordCount}, 32'd0);
    check("t7_wrapErr",   {31'd0, wrapErr},   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t7_idle_after", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the instruction-memory interface.
- Accepts a byte stream (valid/ready), assembles big-endian 32-bit instruction words, and drives a synchronous write port into the instruction bank at word-aligned byte addresses.
- Replaces file-based preload, so a program can be loaded in-system before the CPU is released; busy is used to hold the core in reset.

Parameters:
- ADDR_W, 8, byte-address width of the instruction bank.
- DATA_W, 32, instruction word width; must be 4 bytes.
- CNT_W, 7, width of word-count fields; max load = 2^(ADDR_W-2) = 64 words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- startAddr  in  ADDR_W  first byte address; bits [1:0] are ignored (forced 0).
- numWords  in  CNT_W  words to load; latched on start.
- abort  in  1  cancels the load; any partial word is discarded.
- byteIn  in  8  stream data.
- byteValid  in  1  stream data valid.
- byteReady  out  1  loader can accept a byte this cycle.
- wrEn  out  1  memory write strobe, one cycle per word.
- wrAddr  out  ADDR_W  byte address of the word being written; always a multiple of 4.
- wrData  out  DATA_W  assembled word.
- busy  out  1  high in RECV or WRITE.
- done  out  1  one-cycle pulse when the load completes.
- wrapErr  out  1  sticky; address wrapped past the top of the bank; cleared by the next accepted start.
- wordCount  out  CNT_W  words written so far in the current load.

Behaviour:
- Reset (async): state=IDLE; byteReady=0, wrEn=0, wrAddr=0, wrData=0, busy=0, done=0, wrapErr=0, wordCount=0, byte index=0.
- States and transitions:
  - IDLE: on start with numWords>0, latch {startAddr[7:2],2'b00} and numWords, clear wordCount and wrapErr, go to RECV. On start with numWords==0, clear wrapErr, pulse done next cycle, stay IDLE.
  - RECV: byteReady=1. A byte transfers when byteValid&&byteReady. Byte index 0..3 fills bits [31:24],[23:16],[15:8],[7:0] in that order. On the 4th transfer, go to WRITE.
  - WRITE: byteReady=0. wrEn=1 for exactly this one cycle, with wrAddr and wrData stable. At the end of the cycle:
    - wordCount+=1; wrAddr+=4 modulo 2^ADDR_W.
    - If wrAddr was 0xFC and more words remain, it becomes 0x00 and wrapErr is set.
    - If wordCount+1==numWords, go to IDLE and assert done for one cycle; otherwise return to RECV.
- Latency: wrEn is asserted in the cycle immediately after the 4th byte is accepted. Sustained throughput is 4 bytes per 5 cycles.
- start while busy: ignored, with no change to the latched values.
- abort: takes priority over every transfer in the same cycle, including one in WRITE. Next state is IDLE, no wrEn, no done; the byte index is cleared. wordCount and wrAddr hold their values for debug until the next start.
- byteValid with no byteReady (IDLE/WRITE): the byte is not consumed, and the source must hold it.
- byteValid low mid-word: the loader waits in RECV indefinitely and keeps partial bytes.
- busy is combinational from state. done and wrEn are registered outputs.
- numWords above 64 is legal: the address wraps and wrapErr is set, so earlier words are overwritten.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RECV=2'd1, WRITE=2'd2), the BYTES_PER_WORD=4 constant, and the bank-depth constant shared with the instruction memory.
- One natural sub-module, byte_to_word_packer: byte index counter plus shift/assembly register, with a wordReady flag. The FSM and the address/count logic stay in the top module.

Test Plan:
- Load 3 words at startAddr 0x00. Stream 0x20,0x08,0x00,0x05 / 0x00,0x00,0x00,0x00 / 0xAC,0x01,0x00,0x04 -> three wrEn pulses:
  - wrAddr 0x00 with 0x20080005
  - wrAddr 0x04 with 0x00000000
  - wrAddr 0x08 with 0xAC010004
  - done pulses once, then wordCount=3 and busy=0.
- startAddr 0x06, 1 word, bytes 0x11,0x22,0x33,0x44 -> wrAddr=0x04, wrData=0x11223344.
- Gapped byteValid (one byte every 3 cycles) -> same data as the full-rate case; byteReady is low during every WRITE cycle; no bytes are lost or duplicated.
- startAddr 0xFC, numWords=2 -> writes at 0xFC then 0x00; wrapErr=1 after the second write; a new start clears it.
- Abort after 2 bytes of word 1 -> no wrEn, no done, IDLE next cycle. A new load of 1 word then writes the freshly sent bytes only.
- numWords=0 -> done pulses one cycle after start, with no wrEn and no byteReady. Asserting rst mid-WRITE -> wrEn drops immediately and all outputs return to their reset values.
